// File: rtl/idma_rd_pkg.sv
// Shared constants, state encoding and command record for the iDMA 128b read data packer.
package idma_rd_pkg;

   localparam int DATA_W = 128;
   localparam int STRB_W = DATA_W / 8;
   localparam int LEN_W  = 9;
   localparam int FIFO_W = STRB_W + DATA_W;
   localparam int OFF_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BEAT = 1'b1
   } rd_state_e;

   typedef struct packed {
      logic [LEN_W-1:0] beats;
      logic [OFF_W-1:0] first_off;
      logic [OFF_W-1:0] last_off;
      logic             last;
   } rd_cmd_t;

endpackage

// File: rtl/idma_rd_strb_gen.sv
// Byte strobe for one R beat: leading bytes masked on the first beat, trailing bytes on the final one.
module idma_rd_strb_gen
   import idma_rd_pkg::*;
(
   input  logic [OFF_W-1:0]  first_off,
   input  logic [OFF_W-1:0]  last_off,
   input  logic              first_beat,
   input  logic              final_beat,
   output logic [STRB_W-1:0] strb
);

   always_comb begin
      strb = '0;
      for (int i = 0; i < STRB_W; i++) begin
         strb[i] = (!first_beat || (i >= int'(first_off))) &&
                   (!final_beat || (i <= int'(last_off)));
      end
   end

endmodule

// File: rtl/axi_rd_data_pack_128b.sv
// AXI R beat packer: tags each beat with its alignment strobe and pushes {strb,data} into the data FIFO.
// Optional rlast consistency check enabled by defining IDMA_RD_RLAST_CHK_EN.
//
// state | meaning
// IDLE  | no burst open, waiting for a command
// BEAT  | burst open, forwarding R beats while the FIFO has room
module axi_rd_data_pack_128b
   import idma_rd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sw_init,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_beats,
   input  logic [OFF_W-1:0]  cmd_first_off,
   input  logic [OFF_W-1:0]  cmd_last_off,
   input  logic              cmd_last,
   input  logic              axi_rvalid,
   output logic              axi_rready,
   input  logic [DATA_W-1:0] axi_rdata,
   input  logic [1:0]        axi_rresp,
   input  logic              axi_rlast,
   output logic              data_fifo_push,
   output logic [FIFO_W-1:0] data_fifo_data_in,
   input  logic              data_fifo_full,
   output logic              data_fifo_init,
   output logic              xfer_done,
   output logic              err_resp,
   output logic              err_last
);

   rd_state_e        state_q, state_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [OFF_W-1:0] first_off_q, first_off_d;
   logic [OFF_W-1:0] last_off_q, last_off_d;
   logic             last_q, last_d;
   logic             first_q, first_d;
   logic             err_resp_q, err_resp_d;
   logic             err_last_q, err_last_d;
   logic             xfer_done_q, xfer_done_d;

   rd_cmd_t          cmd_in;
   logic             final_beat;
   logic             fire;
   logic             load_cmd;
   logic [STRB_W-1:0] strb;

   assign cmd_in     = '{beats: cmd_beats, first_off: cmd_first_off,
                         last_off: cmd_last_off, last: cmd_last};
   assign final_beat = (beat_cnt_q == LEN_W'(1));

   idma_rd_strb_gen u_strb_gen (
      .first_off  (first_off_q),
      .last_off   (last_off_q),
      .first_beat (first_q),
      .final_beat (final_beat),
      .strb       (strb)
   );

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      first_off_d = first_off_q;
      last_off_d  = last_off_q;
      last_d      = last_q;
      first_d     = first_q;
      err_resp_d  = err_resp_q;
      err_last_d  = err_last_q;
      xfer_done_d = 1'b0;
      cmd_ready   = 1'b0;
      axi_rready  = 1'b0;
      fire        = 1'b0;
      load_cmd    = 1'b0;

      if (sw_init) begin
         state_d     = IDLE;
         beat_cnt_d  = '0;
         first_off_d = '0;
         last_off_d  = '0;
         last_d      = 1'b0;
         first_d     = 1'b0;
         err_resp_d  = 1'b0;
         err_last_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // rst_n gate keeps cmd_ready low while reset is asserted
               cmd_ready = rst_n;
               load_cmd  = cmd_valid;
            end
            BEAT: begin
               axi_rready = !data_fifo_full;
               fire       = axi_rvalid && !data_fifo_full;
               if (fire) begin
                  first_d    = 1'b0;
                  beat_cnt_d = beat_cnt_q - LEN_W'(1);
                  if (axi_rresp != 2'b00) err_resp_d = 1'b1;
`ifdef IDMA_RD_RLAST_CHK_EN
                  if (axi_rlast != final_beat) err_last_d = 1'b1;
`endif
                  if (final_beat) begin
                     cmd_ready   = 1'b1;
                     xfer_done_d = last_q;
                     load_cmd    = cmd_valid;
                     if (!cmd_valid) state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (load_cmd) begin
            state_d     = BEAT;
            beat_cnt_d  = cmd_in.beats;
            first_off_d = cmd_in.first_off;
            last_off_d  = cmd_in.last_off;
            last_d      = cmd_in.last;
            first_d     = 1'b1;
         end
      end
   end

`ifndef IDMA_RD_RLAST_CHK_EN
   logic unused_rlast;
   assign unused_rlast = axi_rlast;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         first_off_q <= '0;
         last_off_q  <= '0;
         last_q      <= 1'b0;
         first_q     <= 1'b0;
         err_resp_q  <= 1'b0;
         err_last_q  <= 1'b0;
         xfer_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         first_off_q <= first_off_d;
         last_off_q  <= last_off_d;
         last_q      <= last_d;
         first_q     <= first_d;
         err_resp_q  <= err_resp_d;
         err_last_q  <= err_last_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   assign data_fifo_push    = fire;
   assign data_fifo_data_in = fire ? {strb, axi_rdata} : '0;
   assign data_fifo_init    = sw_init;
   assign xfer_done         = xfer_done_q;
   assign err_resp          = err_resp_q;
   assign err_last          = err_last_q;

endmodule

// File: tb/tb_axi_rd_data_pack_128b.sv
// Directed self-checking bench for axi_rd_data_pack_128b; honours IDMA_RD_RLAST_CHK_EN for err_last expectations.
module tb_axi_rd_data_pack_128b;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sw_init;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [8:0]   cmd_beats;
   logic [3:0]   cmd_first_off;
   logic [3:0]   cmd_last_off;
   logic         cmd_last;
   logic         axi_rvalid;
   logic         axi_rready;
   logic [127:0] axi_rdata;
   logic [1:0]   axi_rresp;
   logic         axi_rlast;
   logic         data_fifo_push;
   logic [143:0] data_fifo_data_in;
   logic         data_fifo_full;
   logic         data_fifo_init;
   logic         xfer_done;
   logic         err_resp;
   logic         err_last;

   int checks = 0;
   int errors = 0;

`ifdef IDMA_RD_RLAST_CHK_EN
   localparam logic EXP_ERR_LAST = 1'b1;
`else
   localparam logic EXP_ERR_LAST = 1'b0;
`endif

   always #5 clk = ~clk;

   axi_rd_data_pack_128b dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .sw_init           (sw_init),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_beats         (cmd_beats),
      .cmd_first_off     (cmd_first_off),
      .cmd_last_off      (cmd_last_off),
      .cmd_last          (cmd_last),
      .axi_rvalid        (axi_rvalid),
      .axi_rready        (axi_rready),
      .axi_rdata         (axi_rdata),
      .axi_rresp         (axi_rresp),
      .axi_rlast         (axi_rlast),
      .data_fifo_push    (data_fifo_push),
      .data_fifo_data_in (data_fifo_data_in),
      .data_fifo_full    (data_fifo_full),
      .data_fifo_init    (data_fifo_init),
      .xfer_done         (xfer_done),
      .err_resp          (err_resp),
      .err_last          (err_last)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [8:0] beats, input logic [3:0] fo,
                          input logic [3:0] lo, input logic last);
      cmd_valid     = 1'b1;
      cmd_beats     = beats;
      cmd_first_off = fo;
      cmd_last_off  = lo;
      cmd_last      = last;
   endtask

   task automatic set_beat(input logic [127:0] d, input logic [1:0] resp, input logic last);
      axi_rvalid = 1'b1;
      axi_rdata  = d;
      axi_rresp  = resp;
      axi_rlast  = last;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sw_init = 1'b0; cmd_valid = 1'b0; cmd_beats = '0;
      cmd_first_off = '0; cmd_last_off = '0; cmd_last = 1'b0;
      axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
      data_fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cmd_ready, axi_rready, data_fifo_push, data_fifo_init, xfer_done, err_resp, err_last} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {cmd_ready, axi_rready, data_fifo_push, data_fifo_init, xfer_done, err_resp, err_last});
      end
      checks++;
      if (data_fifo_data_in !== 144'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", data_fifo_data_in);
      end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || axi_rready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: cmd_ready=%b rready=%b want 1 0", cmd_ready, axi_rready);
      end
      next_cycle();
   endtask

   task automatic test_four_beat();
      logic [15:0]  exp_strb [4];
      logic [127:0] d;
      exp_strb = '{16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h03FF};
      set_cmd(9'd4, 4'd3, 4'd9, 1'b0);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL four_cmd_ready: got %b want 1", cmd_ready);
      end
      next_cycle();
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         d = {4{32'h1111_0000 + 32'(k)}};
         set_beat(d, 2'b00, k == 3);
         @(negedge clk);
         checks++;
         if (data_fifo_push !== 1'b1 || data_fifo_data_in !== {exp_strb[k], d}) begin
            errors++;
            $display("FAIL four_beat%0d: push=%b strb=%h want push=1 strb=%h", k,
                     data_fifo_push, data_fifo_data_in[143:128], exp_strb[k]);
         end
         checks++;
         if (cmd_ready !== (k == 3)) begin
            errors++;
            $display("FAIL four_cmd_ready_beat%0d: got %b want %b", k, cmd_ready, k == 3);
         end
         next_cycle();
      end
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || axi_rready !== 1'b0 || xfer_done !== 1'b0) begin
         errors++;
         $display("FAIL four_end: cmd_ready=%b rready=%b xfer_done=%b want 1 0 0",
                  cmd_ready, axi_rready, xfer_done);
      end
      next_cycle();
   endtask

   task automatic test_single_beat();
      logic [127:0] d;
      d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
      set_cmd(9'd1, 4'd4, 4'd7, 1'b1);
      next_cycle();
      cmd_valid = 1'b0;
      set_beat(d, 2'b00, 1'b1);
      @(negedge clk);
      checks++;
      if (data_fifo_push !== 1'b1 || data_fifo_data_in !== {16'h00F0, d} || xfer_done !== 1'b0) begin
         errors++;
         $display("FAIL single_beat: push=%b strb=%h xfer_done=%b want 1 00f0 0",
                  data_fifo_push, data_fifo_data_in[143:128], xfer_done);
      end
      next_cycle();
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (xfer_done !== 1'b1) begin
         errors++;
         $display("FAIL single_xfer_done: got %b want 1", xfer_done);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (xfer_done !== 1'b0) begin
         errors++;
         $display("FAIL single_xfer_done_clear: got %b want 0", xfer_done);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [15:0]  exp_strb [4];
      logic [127:0] d;
      exp_strb = '{16'hFFFF, 16'hFFFF, 16'hFFFC, 16'h003F};
      set_cmd(9'd2, 4'd0, 4'd15, 1'b0);
      next_cycle();
      set_cmd(9'd2, 4'd2, 4'd5, 1'b1);
      for (int k = 0; k < 4; k++) begin
         if (k == 2) cmd_valid = 1'b0;
         d = {4{32'hB2B0_0000 + 32'(k)}};
         set_beat(d, 2'b00, (k == 1) || (k == 3));
         @(negedge clk);
         checks++;
         if (data_fifo_push !== 1'b1 || data_fifo_data_in !== {exp_strb[k], d}) begin
            errors++;
            $display("FAIL b2b_beat%0d: push=%b strb=%h want push=1 strb=%h", k,
                     data_fifo_push, data_fifo_data_in[143:128], exp_strb[k]);
         end
         next_cycle();
      end
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (xfer_done !== 1'b1 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end: xfer_done=%b cmd_ready=%b want 1 1", xfer_done, cmd_ready);
      end
      next_cycle();
   endtask

   task automatic test_full_stall();
      logic [127:0] d;
      set_cmd(9'd3, 4'd1, 4'd14, 1'b0);
      next_cycle();
      cmd_valid = 1'b0;
      d = {4{32'h5555_0000}};
      set_beat(d, 2'b00, 1'b0);
      @(negedge clk);
      checks++;
      if (data_fifo_push !== 1'b1 || data_fifo_data_in !== {16'hFFFE, d}) begin
         errors++;
         $display("FAIL stall_beat0: push=%b strb=%h want 1 fffe",
                  data_fifo_push, data_fifo_data_in[143:128]);
      end
      next_cycle();
      d = {4{32'h5555_0001}};
      set_beat(d, 2'b00, 1'b0);
      data_fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (axi_rready !== 1'b0 || data_fifo_push !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d: rready=%b push=%b want 0 0", k, axi_rready, data_fifo_push);
         end
         next_cycle();
      end
      data_fifo_full = 1'b0;
      @(negedge clk);
      checks++;
      if (data_fifo_push !== 1'b1 || data_fifo_data_in !== {16'hFFFF, d}) begin
         errors++;
         $display("FAIL stall_beat1: push=%b strb=%h want 1 ffff",
                  data_fifo_push, data_fifo_data_in[143:128]);
      end
      next_cycle();
      d = {4{32'h5555_0002}};
      set_beat(d, 2'b00, 1'b1);
      @(negedge clk);
      checks++;
      if (data_fifo_push !== 1'b1 || data_fifo_data_in !== {16'h7FFF, d}) begin
         errors++;
         $display("FAIL stall_beat2: push=%b strb=%h want 1 7fff",
                  data_fifo_push, data_fifo_data_in[143:128]);
      end
      next_cycle();
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_end_idle: cmd_ready=%b want 1", cmd_ready);
      end
      next_cycle();
   endtask

   task automatic test_err_resp();
      set_cmd(9'd3, 4'd0, 4'd15, 1'b0);
      next_cycle();
      cmd_valid = 1'b0;
      set_beat({4{32'hE000_0000}}, 2'b00, 1'b0);
      next_cycle();
      checks++;
      if (err_resp !== 1'b0) begin
         errors++;
         $display("FAIL err_resp_early: got %b want 0", err_resp);
      end
      set_beat({4{32'hE000_0001}}, 2'b10, 1'b0);
      @(negedge clk);
      checks++;
      if (data_fifo_push !== 1'b1) begin
         errors++;
         $display("FAIL err_beat_pushed: push=%b want 1", data_fifo_push);
      end
      next_cycle();
      set_beat({4{32'hE000_0002}}, 2'b00, 1'b1);
      next_cycle();
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (err_resp !== 1'b1 || err_last !== 1'b0) begin
         errors++;
         $display("FAIL err_resp_sticky: err_resp=%b err_last=%b want 1 0", err_resp, err_last);
      end
      next_cycle();
      // abandon a burst mid-flight with sw_init
      set_cmd(9'd4, 4'd0, 4'd15, 1'b1);
      next_cycle();
      cmd_valid = 1'b0;
      set_beat({4{32'hE000_0003}}, 2'b00, 1'b0);
      next_cycle();
      sw_init = 1'b1;
      @(negedge clk);
      checks++;
      if (data_fifo_init !== 1'b1 || cmd_ready !== 1'b0 || axi_rready !== 1'b0 || data_fifo_push !== 1'b0) begin
         errors++;
         $display("FAIL sw_init_cycle: init=%b cmd_ready=%b rready=%b push=%b want 1 0 0 0",
                  data_fifo_init, cmd_ready, axi_rready, data_fifo_push);
      end
      next_cycle();
      sw_init = 1'b0;
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (err_resp !== 1'b0 || cmd_ready !== 1'b1 || axi_rready !== 1'b0 || data_fifo_init !== 1'b0) begin
         errors++;
         $display("FAIL sw_init_after: err_resp=%b cmd_ready=%b rready=%b init=%b want 0 1 0 0",
                  err_resp, cmd_ready, axi_rready, data_fifo_init);
      end
      next_cycle();
   endtask

   task automatic test_rlast();
      set_cmd(9'd2, 4'd0, 4'd15, 1'b0);
      next_cycle();
      cmd_valid = 1'b0;
      set_beat({4{32'hC000_0000}}, 2'b00, 1'b1);
      next_cycle();
      set_beat({4{32'hC000_0001}}, 2'b00, 1'b1);
      @(negedge clk);
      checks++;
      if (data_fifo_push !== 1'b1 || data_fifo_data_in[143:128] !== 16'hFFFF) begin
         errors++;
         $display("FAIL rlast_beat1: push=%b strb=%h want 1 ffff",
                  data_fifo_push, data_fifo_data_in[143:128]);
      end
      next_cycle();
      axi_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (err_last !== EXP_ERR_LAST || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rlast_err: err_last=%b cmd_ready=%b want %b 1", err_last, cmd_ready, EXP_ERR_LAST);
      end
      next_cycle();
      sw_init = 1'b1;
      next_cycle();
      sw_init = 1'b0;
      @(negedge clk);
      checks++;
      if (err_last !== 1'b0) begin
         errors++;
         $display("FAIL rlast_clear: err_last=%b want 0", err_last);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_four_beat();
      test_single_beat();
      test_back_to_back();
      test_full_stall();
      test_err_resp();
      test_rlast();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
